// File: rtl/scan_decoder.sv
// One-hot decoder with direct-select and auto-scan modes; each scanned channel is held DIV cycles.
// Optional anti-ghost blanking of the last cycle per channel: define SCAN_DECODER_BLANK_EN.
module scan_decoder #(
    parameter int N   = 2,
    parameter int DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        I,
    input  logic                E,
    input  logic                mode,
    output logic [(1<<N)-1:0]   O,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int              M       = 1 << N;
    localparam int              PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(DIV - 1);
    localparam logic [N-1:0]    IDX_MAX = {N{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    state_e          state;
    logic [M-1:0]    o_q, o_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            wrap_q, wrap_d;
    logic            mode_prev_q, mode_prev_d;

    always_comb begin
        state = ST_IDLE;
        if (E) begin
            state = mode ? ST_SCAN : ST_DIRECT;
        end
    end

    always_comb begin
        o_d         = '0;
        idx_d       = idx_q;
        pre_d       = pre_q;
        wrap_d      = 1'b0;
        mode_prev_d = mode;
        case (state)
            ST_DIRECT: begin
                idx_d    = I;
                pre_d    = '0;
                o_d[I]   = 1'b1;
            end
            ST_SCAN: begin
                // mode_prev_q is cleared by reset, so the first scan after reset is a fresh entry
                if (!mode_prev_q) begin
                    idx_d = '0;
                    pre_d = '0;
                end else if (pre_q == PRE_MAX) begin
                    pre_d  = '0;
                    idx_d  = idx_q + 1'b1;
                    wrap_d = (idx_q == IDX_MAX);
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                o_d[idx_d] = 1'b1;
`ifdef SCAN_DECODER_BLANK_EN
                if (pre_d == PRE_MAX) begin
                    o_d = '0;
                end
`endif
            end
            default: begin
                o_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q         <= '0;
            idx_q       <= '0;
            pre_q       <= '0;
            wrap_q      <= 1'b0;
            mode_prev_q <= 1'b0;
        end else begin
            o_q         <= o_d;
            idx_q       <= idx_d;
            pre_q       <= pre_d;
            wrap_q      <= wrap_d;
            mode_prev_q <= mode_prev_d;
        end
    end

    assign O    = o_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed-vector bench for scan_decoder (N=2, DIV=4): table-driven vectors plus freeze/reset sequences.
module tb_scan_decoder;

    localparam int N   = 2;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] I;
    logic         E;
    logic         mode;
    logic [3:0]   O;
    logic [N-1:0] idx;
    logic         wrap;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       rst;
        logic       e;
        logic       m;
        logic [1:0] i;
        logic [3:0] o;
        logic [1:0] ix;
        logic       w;
        logic       blk;
        string      name;
    } vec_t;

    vec_t vecs[$];

    scan_decoder #(.N(N), .DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .I    (I),
        .E    (E),
        .mode (mode),
        .O    (O),
        .idx  (idx),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic e, input logic m, input logic [1:0] i,
                                input logic [3:0] o, input logic [1:0] ix, input logic w,
                                input logic blk, input string name);
        vec_t v;
        v.rst = r; v.e = e; v.m = m; v.i = i;
        v.o = o; v.ix = ix; v.w = w; v.blk = blk; v.name = name;
        vecs.push_back(v);
    endfunction

    // Drive one cycle, then check outputs 1 time unit after the rising edge.
    task automatic step(input vec_t v);
        logic [3:0] eo;
        eo = v.o;
`ifdef SCAN_DECODER_BLANK_EN
        if (v.blk) eo = 4'b0000;
`endif
        rst = v.rst; E = v.e; mode = v.m; I = v.i;
        @(posedge clk);
        #1;
        n_vec++;
        if (O !== eo || idx !== v.ix || wrap !== v.w) begin
            n_miss++;
            $display("FAIL %s: got O=%b idx=%0d wrap=%b, expected O=%b idx=%0d wrap=%b",
                     v.name, O, idx, wrap, eo, v.ix, v.w);
        end
    endtask

    task automatic hstep(input logic r, input logic e, input logic m, input logic [1:0] i,
                         input logic [3:0] o, input logic [1:0] ix, input logic w,
                         input logic blk, input string name);
        vec_t v;
        v.rst = r; v.e = e; v.m = m; v.i = i;
        v.o = o; v.ix = ix; v.w = w; v.blk = blk; v.name = name;
        step(v);
    endtask

    initial begin
        rst = 1'b1; E = 1'b1; mode = 1'b1; I = '0;

        add(1, 1, 1, 0, 4'b0000, 0, 0, 0, "reset_a");
        add(1, 1, 1, 0, 4'b0000, 0, 0, 0, "reset_b");
        add(0, 1, 0, 0, 4'b0001, 0, 0, 0, "direct_0");
        add(0, 1, 0, 1, 4'b0010, 1, 0, 0, "direct_1");
        add(0, 1, 0, 2, 4'b0100, 2, 0, 0, "direct_2");
        add(0, 1, 0, 3, 4'b1000, 3, 0, 0, "direct_3");
        add(0, 0, 0, 2, 4'b0000, 3, 0, 0, "direct_disable");
        add(0, 1, 0, 1, 4'b0010, 1, 0, 0, "direct_again");
        // Scan entry from direct mode: channel c holds for 4 cycles, wrap only in cycle 17.
        for (int c = 1; c <= 26; c++) begin
            int ch;
            ch = ((c - 1) / DIV) % 4;
            add(0, 1, 1, 0, 4'b0001 << ch, ch[1:0], (c == 17), ((c - 1) % DIV) == DIV - 1, "scan");
        end

        foreach (vecs[k]) step(vecs[k]);

        // Freeze during channel 2 at prescaler 1, then resume without reload.
        hstep(0, 0, 1, 0, 4'b0000, 2, 0, 0, "freeze_1");
        hstep(0, 0, 1, 0, 4'b0000, 2, 0, 0, "freeze_2");
        hstep(0, 0, 1, 0, 4'b0000, 2, 0, 0, "freeze_3");
        hstep(0, 1, 1, 0, 4'b0100, 2, 0, 0, "resume_p2");
        hstep(0, 1, 1, 0, 4'b0100, 2, 0, 1, "resume_p3");
        hstep(0, 1, 1, 0, 4'b1000, 3, 0, 0, "resume_ch3_p0");
        hstep(0, 1, 1, 0, 4'b1000, 3, 0, 0, "resume_ch3_p1");
        hstep(0, 1, 1, 0, 4'b1000, 3, 0, 0, "resume_ch3_p2");
        hstep(0, 1, 1, 0, 4'b1000, 3, 0, 1, "resume_ch3_p3");
        // Leave scan with a wrap pending: direct takes over, wrap stays low.
        hstep(0, 1, 0, 2, 4'b0100, 2, 0, 0, "wrap_suppressed");
        hstep(0, 1, 1, 3, 4'b0001, 0, 0, 0, "reentry");
        hstep(0, 1, 1, 3, 4'b0001, 0, 0, 0, "reentry_p1");
        hstep(0, 1, 1, 3, 4'b0001, 0, 0, 0, "reentry_p2");
        // Reset mid-scan wins over E/mode/I, then scan restarts with a full first channel.
        hstep(1, 1, 0, 3, 4'b0000, 0, 0, 0, "reset_mid_scan");
        hstep(0, 1, 1, 2, 4'b0001, 0, 0, 0, "restart_p0");
        hstep(0, 1, 1, 2, 4'b0001, 0, 0, 0, "restart_p1");
        hstep(0, 1, 1, 2, 4'b0001, 0, 0, 0, "restart_p2");
        hstep(0, 1, 1, 2, 4'b0001, 0, 0, 1, "restart_p3");
        hstep(0, 1, 1, 2, 4'b0010, 1, 0, 0, "restart_ch1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
